// File: rtl/frame_pad_feeder_pkg.sv
// Shared definitions for the linebuf feeder: image defaults, border byte,
// FSM encodings and the registered output beat.
package frame_pad_feeder_pkg;

  localparam int DEF_WIDTH = 354;
  localparam int DEF_HIGH  = 425;

  localparam logic [7:0] BORDER_BYTE = 8'd0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_TAILS = 2'd2;

  typedef struct packed {
    logic       shift_en;
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } out_beat_t;

  localparam out_beat_t OUT_IDLE = '{shift_en: 1'b0, data: 8'd0, sof: 1'b0, eof: 1'b0};

endpackage

// File: rtl/frame_pad_feeder_sync_fifo.sv
// First-word fall-through FIFO holding raw input pixels ahead of the frame stream.
// Push is refused whenever full, even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 1024,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DW-1:0]              din_i,
  output logic [DW-1:0]              dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_pad_feeder.sv
// Linebuf feeder: buffers raw pixels and emits each frame as one gap-free
// bordered byte stream followed by TAIL drain zeros.
//
// state | meaning
// IDLE  | waiting for FIFO occupancy to reach START_LEVEL
// FRAME | one bordered-frame byte per cycle, row/col track the byte on data_o
// TAILS | trailing zeros that flush the conv valid pipe
module frame_pad_feeder
  import frame_pad_feeder_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HIGH        = DEF_HIGH,
  parameter int FIFO_DEPTH  = 1024,
  parameter int START_LEVEL = 354,
  parameter int TAIL        = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       shift_en_o,
  output logic [7:0] data_o,
  output logic       sof_o,
  output logic       eof_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int CW   = $clog2(WIDTH + 2);
  localparam int RW   = $clog2(HIGH + 2);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW   = (TAIL > 1) ? $clog2(TAIL) : 1;

  logic [1:0]      state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [TW-1:0]   tail_q, tail_d;
  out_beat_t       out_q, out_d;
  logic            underrun_q, underrun_d;

  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CNTW-1:0] fifo_count;
  logic            start, last_col, last_row, interior, at_last_d;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (in_valid_i),
    .pop_i   (fifo_pop),
    .din_i   (in_data_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign start    = (fifo_count >= CNTW'(START_LEVEL));
  assign last_col = (col_q == CW'(WIDTH + 1));
  assign last_row = (row_q == RW'(HIGH + 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tail_d  = tail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FRAME;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_FRAME: begin
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            row_d = '0;
            if (TAIL == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_TAILS;
              tail_d  = TW'(TAIL - 1);
            end
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      ST_TAILS: begin
        if (tail_q == '0) state_d = ST_IDLE;
        else              tail_d  = tail_q - TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers load the byte for the position being entered, so the
  // FIFO pop lines up with the cycle that byte becomes visible.
  always_comb begin
    interior = (state_d == ST_FRAME) &&
               (row_d != '0) && (row_d <= RW'(HIGH)) &&
               (col_d != '0) && (col_d <= CW'(WIDTH));
    at_last_d = (row_d == RW'(HIGH + 1)) && (col_d == CW'(WIDTH + 1));
    fifo_pop       = interior && !fifo_empty;
    out_d.shift_en = (state_d != ST_IDLE);
    out_d.data     = fifo_pop ? fifo_dout : BORDER_BYTE;
    out_d.sof      = (state_q == ST_IDLE) && (state_d == ST_FRAME);
    out_d.eof      = ((state_d == ST_TAILS) && (tail_d == '0)) ||
                     ((TAIL == 0) && (state_d == ST_FRAME) && at_last_d);
    underrun_d     = underrun_q | (interior & fifo_empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      tail_q     <= '0;
      out_q      <= OUT_IDLE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tail_q     <= tail_d;
      out_q      <= out_d;
      underrun_q <= underrun_d;
    end
  end

  assign in_ready_o = !fifo_full;
  assign shift_en_o = out_q.shift_en;
  assign data_o     = out_q.data;
  assign sof_o      = out_q.sof;
  assign eof_o      = out_q.eof;
  assign busy_o     = (state_q != ST_IDLE);
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_frame_pad_feeder.sv
// Bench for frame_pad_feeder at 4x3 with an 8-deep FIFO: frame-index model
// checked every cycle plus hand-computed stream literals.
module tb_frame_pad_feeder;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int D   = 8;
  localparam int SL  = 4;
  localparam int TL  = 4;
  localparam int FB  = (W + 2) * (H + 2);
  localparam int TOT = FB + TL;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, shift_en, sof, eof, busy, underrun;
  logic [7:0] data;

  logic       in8_valid = 1'b0;
  logic [7:0] in8_data = 8'd0;
  logic       in8_ready, shift8, sof8, eof8, busy8, urun8;
  logic [7:0] data8;

  always #5 clk = ~clk;

  frame_pad_feeder #(.WIDTH(W), .HIGH(H), .FIFO_DEPTH(D), .START_LEVEL(SL), .TAIL(TL)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .shift_en_o(shift_en), .data_o(data), .sof_o(sof),
    .eof_o(eof), .busy_o(busy), .underrun_o(underrun));

  frame_pad_feeder #(.WIDTH(W), .HIGH(H), .FIFO_DEPTH(D), .START_LEVEL(8), .TAIL(TL)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in8_valid), .in_data_i(in8_data),
    .in_ready_o(in8_ready), .shift_en_o(shift8), .data_o(data8), .sof_o(sof8),
    .eof_o(eof8), .busy_o(busy8), .underrun_o(urun8));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: the stream is a sequence of frame byte indices; interior
  // indices consume the oldest queued pixel, or zero plus underrun if none.
  logic [7:0] mq[$];
  int         m_pos = -1;
  bit         m_urun = 1'b0;
  bit         e_shift = 1'b0, e_sof = 1'b0, e_eof = 1'b0;
  logic [7:0] e_data = 8'd0;

  always @(posedge clk or negedge reset_n) begin : model
    int pre, nxt, r, c;
    logic [7:0] d;
    if (!reset_n) begin
      mq.delete();
      m_pos = -1; m_urun = 1'b0;
      e_shift = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_data = 8'd0;
    end else begin
      pre = mq.size();
      if (m_pos < 0) nxt = (pre >= SL) ? 0 : -1;
      else           nxt = (m_pos + 1 == TOT) ? -1 : m_pos + 1;
      d = 8'd0;
      if (nxt >= 0 && nxt < FB) begin
        r = nxt / (W + 2);
        c = nxt % (W + 2);
        if (r >= 1 && r <= H && c >= 1 && c <= W) begin
          if (mq.size() > 0) d = mq.pop_front();
          else               m_urun = 1'b1;
        end
      end
      if (in_valid && pre < D) mq.push_back(in_data);
      m_pos   = nxt;
      e_shift = (nxt >= 0);
      e_sof   = (nxt == 0);
      e_eof   = (nxt == TOT - 1);
      e_data  = d;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("cyc_shift_en", int'(shift_en), int'(e_shift));
      check("cyc_data", int'(data), int'(e_data));
      check("cyc_sof", int'(sof), int'(e_sof));
      check("cyc_eof", int'(eof), int'(e_eof));
      check("cyc_busy", int'(busy), int'(m_pos >= 0));
      check("cyc_underrun", int'(underrun), int'(m_urun));
      check("cyc_in_ready", int'(in_ready), int'(mq.size() < D));
    end
  end

  int cap_n = 0;
  int cap_data[512], cap_sof[512], cap_eof[512], cap_cyc[512];
  int cap8_n = 0;
  int cap8_data[64], cap8_eof[64];

  always @(negedge clk) begin
    if (reset_n && shift_en && cap_n < 512) begin
      cap_data[cap_n] = int'(data);
      cap_sof[cap_n]  = int'(sof);
      cap_eof[cap_n]  = int'(eof);
      cap_cyc[cap_n]  = cyc;
      cap_n++;
    end
    if (reset_n && shift8 && cap8_n < 64) begin
      cap8_data[cap8_n] = int'(data8);
      cap8_eof[cap8_n]  = int'(eof8);
      cap8_n++;
    end
  end

  int lit1[TOT] = '{0, 0, 0, 0, 0, 0,
                    0, 1, 2, 3, 4, 0,
                    0, 5, 6, 7, 8, 0,
                    0, 9, 10, 11, 12, 0,
                    0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0};

  // Called at a negedge; returns at a negedge.
  task automatic push_seq(input int first, input int n, input int budget);
    int i = 0;
    int t = 0;
    bit rdy;
    while (i < n && t < budget) begin
      in_valid = 1'b1;
      in_data  = 8'(first + i);
      rdy      = in_ready;
      @(negedge clk);
      if (rdy) i++;
      t++;
    end
    in_valid = 1'b0;
    if (i < n) check("push_timeout", i, n);
  endtask

  task automatic wait_strobes(input int base, input int n, input int budget);
    int t = 0;
    while (cap_n - base < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    if (cap_n - base < n) check("strobe_timeout", cap_n - base, n);
  endtask

  task automatic check_burst(input string tag, input int base, input int offs);
    int nsof = 0;
    for (int i = 0; i < TOT; i++) begin
      check({tag, "_byte"}, cap_data[base + i], (lit1[i] == 0) ? 0 : lit1[i] + offs);
      nsof += cap_sof[base + i];
    end
    check({tag, "_sof_first"}, cap_sof[base], 1);
    check({tag, "_sof_count"}, nsof, 1);
    check({tag, "_eof_last"}, cap_eof[base + TOT - 1], 1);
    check({tag, "_eof_early"}, cap_eof[base + TOT - 2], 0);
    check({tag, "_gapfree"}, cap_cyc[base + TOT - 1] - cap_cyc[base], TOT - 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b, lows, t;

    repeat (3) @(negedge clk);
    check("rst_shift_en", int'(shift_en), 0);
    check("rst_data", int'(data), 0);
    check("rst_sof", int'(sof), 0);
    check("rst_eof", int'(eof), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_underrun", int'(underrun), 0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", int'(in_ready), 1);

    // 1: pixels 1..12 at full rate
    b = cap_n;
    push_seq(1, 12, 100);
    wait_strobes(b, TOT, 200);
    repeat (4) @(negedge clk);
    check("t1_strobes", cap_n - b, TOT);
    check_burst("t1", b, 0);
    check("t1_underrun", int'(underrun), 0);

    // 2: only one row of pixels, then the input stalls
    b = cap_n;
    push_seq(1, 4, 20);
    wait_strobes(b, TOT, 200);
    check("t2_row1_c1", cap_data[b + 7], 1);
    check("t2_row1_c4", cap_data[b + 10], 4);
    check("t2_row2_c1", cap_data[b + 13], 0);
    check("t2_underrun", int'(underrun), 1);
    repeat (5) @(negedge clk);
    check("t2_underrun_sticky", int'(underrun), 1);

    // 3: START_LEVEL=8 instance fills the FIFO before its first pop
    for (int i = 0; i < 8; i++) begin
      in8_valid = 1'b1;
      in8_data  = 8'(i + 1);
      @(negedge clk);
    end
    in8_data = 8'd9;
    check("t3_ready_when_full", int'(in8_ready), 0);
    lows = 0;
    while (!in8_ready && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    check("t3_held_cycles", lows, 8);
    @(negedge clk);
    in8_valid = 1'b0;
    t = 0;
    while (cap8_n < TOT && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    check("t3_strobes", cap8_n, TOT);
    check("t3_px1", cap8_data[7], 1);
    check("t3_px8", cap8_data[16], 8);
    check("t3_px9", cap8_data[19], 9);
    check("t3_row3_c2", cap8_data[20], 0);
    check("t3_eof", cap8_eof[TOT - 1], 1);
    check("t3_underrun", int'(urun8), 1);
    @(negedge clk);

    // 4: async reset during strobe 10
    b = cap_n;
    push_seq(1, 8, 40);
    wait_strobes(b, 10, 100);
    reset_n = 1'b0;
    #1;
    check("t4_shift_en", int'(shift_en), 0);
    check("t4_data", int'(data), 0);
    check("t4_sof", int'(sof), 0);
    check("t4_eof", int'(eof), 0);
    check("t4_busy", int'(busy), 0);
    check("t4_underrun", int'(underrun), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("t4_rel_busy", int'(busy), 0);
    check("t4_rel_in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    check("t4_still_idle", int'(shift_en), 0);
    b = cap_n;
    push_seq(1, 12, 100);
    wait_strobes(b, TOT, 200);
    check_burst("t4", b, 0);

    // 5: 24 pixels streamed continuously make two frames
    repeat (3) @(negedge clk);
    b = cap_n;
    push_seq(1, 24, 400);
    wait_strobes(b, 2 * TOT, 400);
    repeat (4) @(negedge clk);
    check("t5_strobes", cap_n - b, 2 * TOT);
    check_burst("t5a", b, 0);
    check_burst("t5b", b + TOT, 12);
    check("t5_idle_gap", int'(cap_cyc[b + TOT] - cap_cyc[b + TOT - 1] >= 2), 1);
    check("t5_underrun", int'(underrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
